// File: rtl/alu_pkg.sv
// Shared definitions for the registered 16-bit ALU and its operation driver.
//   ALU_W        operand/result width of the ALU
//   ALU_LATENCY  cycles from the operand launch edge to y valid
//   alu_op_t     2-bit op select: add, sub, and, or
//   alu_golden() reference result for one op; arithmetic wraps mod 2^ALU_W
package alu_pkg;

  localparam int ALU_W       = 16;
  localparam int ALU_LATENCY = 2;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  function automatic logic [ALU_W-1:0] alu_golden(input logic [ALU_W-1:0] a,
                                                  input logic [ALU_W-1:0] b,
                                                  input alu_op_t op);
    logic [ALU_W-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_driver_if.sv
// Request/response bundle between a command source and alu_op_driver.
//   req_valid/req_ready/req_a/req_b/req_sel  operation request
//   rsp_valid/rsp_ready/rsp_y/rsp_sel        result return (FIFO head)
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1; the sender keeps valid and its data
// stable until that edge, and ready never depends combinationally on valid.
// Modports: master = command source, slave = driver.
interface alu_op_driver_if #(
  parameter int W = 16
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_sel;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic [1:0]   rsp_sel;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_sel
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_sel
  );
endinterface

// File: rtl/alu_rsp_fifo.sv
// First-word-fall-through response FIFO.
//   clk, rst_n  clock, asynchronous active-low reset (clears contents too)
//   push, din   write one entry
//   pop         remove the head entry; dout always shows the head
//   count       number of stored entries; full/empty derived from it
// Push and pop in the same cycle is legal at any occupancy, including full.
module alu_rsp_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // When full, the slot being written is the head that leaves this same edge.
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// Operation driver for the registered ALU (operands registered, sel
// combinational, y registered).
//   clk, rst_n          clock, asynchronous active-low reset
//   io (slave)          request in / response out, see alu_op_driver_if
//   alu_a, alu_b        operands, loaded on the accept edge E
//   alu_sel             op select, one cycle behind the operands (E+1..E+2)
//   alu_y               ALU result, captured at E+3 into the response FIFO
//   err                 sticky result mismatch flag
// Optional build macro ALU_DRIVER_CHECK_EN: adds a golden-model compare at
// capture time that sets err on the first wrong alu_y. Without it err is 0.
module alu_op_driver
  import alu_pkg::*;
#(
  parameter int W          = ALU_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = ALU_LATENCY
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_op_driver_if.slave io,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [1:0]     alu_sel,
  input  logic [W-1:0]   alu_y,
  output logic           err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + ALU_LAT + 1) + 1;

  // v[i] marks an op launched i edges ago; sel_pipe[i] is its select.
  logic [ALU_LAT:0] v;
  logic [1:0]       sel_pipe [ALU_LAT+1];
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    credit;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [W+1:0]     fifo_head;
  logic             accept;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= ALU_LAT; i++) inflight = inflight + CW'(v[i]);
  end

  // Every launched op already owns a FIFO slot, so the ALU path never stalls.
  assign credit       = CW'(fifo_count) + inflight;
  assign io.req_ready = ~fifo_full & (credit < CW'(FIFO_DEPTH));
  assign accept       = io.req_valid & io.req_ready;
  assign alu_sel      = sel_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v     <= '0;
      alu_a <= '0;
      alu_b <= '0;
      for (int i = 0; i <= ALU_LAT; i++) sel_pipe[i] <= '0;
    end else begin
      v <= {v[ALU_LAT-1:0], accept};
      if (accept) begin
        alu_a       <= io.req_a;
        alu_b       <= io.req_b;
        sel_pipe[0] <= io.req_sel;
      end
      // Stages only load behind a valid op, so alu_sel holds while idle.
      for (int i = 1; i <= ALU_LAT; i++)
        if (v[i-1]) sel_pipe[i] <= sel_pipe[i-1];
    end
  end

  alu_rsp_fifo #(
    .W     (W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (v[ALU_LAT]),
    .din   ({sel_pipe[ALU_LAT], alu_y}),
    .pop   (io.rsp_valid & io.rsp_ready),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign io.rsp_valid = ~fifo_empty;
  assign io.rsp_sel   = fifo_head[W+1:W];
  assign io.rsp_y     = fifo_head[W-1:0];

`ifdef ALU_DRIVER_CHECK_EN
  // Operand copies travel with the op so the compare lines up with capture.
  logic [W-1:0] a_pipe [1:ALU_LAT];
  logic [W-1:0] b_pipe [1:ALU_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
      for (int i = 1; i <= ALU_LAT; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      if (v[0]) begin
        a_pipe[1] <= alu_a;
        b_pipe[1] <= alu_b;
      end
      for (int i = 2; i <= ALU_LAT; i++)
        if (v[i-1]) begin
          a_pipe[i] <= a_pipe[i-1];
          b_pipe[i] <= b_pipe[i-1];
        end
      if (v[ALU_LAT] &&
          (alu_y != alu_golden(a_pipe[ALU_LAT], b_pipe[ALU_LAT],
                               alu_op_t'(sel_pipe[ALU_LAT]))))
        err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: a behavioural ALU, randomized and directed
// stimulus, and a cycle-level reference model checked every cycle.
module tb_alu_op_driver;
  import alu_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int NEVER = 32'h7fff_ffff;
`ifdef ALU_DRIVER_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT + ALU ----------------
  alu_op_driver_if #(.W(W)) bus();
  logic [W-1:0] alu_a, alu_b, alu_y;
  logic [1:0]   alu_sel;
  logic         err;

  alu_op_driver #(.W(W), .FIFO_DEPTH(DEPTH), .ALU_LAT(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io      (bus),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_y   (alu_y),
    .err     (err)
  );

  // Registered ALU: operands registered, sel combinational, y registered.
  // c0/c1 carry a one-shot fault that flips y bit0 for one chosen op.
  logic [W-1:0] a_r, b_r, y_r;
  logic         c0 = 1'b0, c1 = 1'b0, c_next = 1'b0;
  always @(posedge clk) begin
    a_r <= alu_a;
    b_r <= alu_b;
    y_r <= alu_golden(a_r, b_r, alu_op_t'(alu_sel)) ^ {{(W-1){1'b0}}, c1};
    c1  <= c0;
    c0  <= c_next;
  end
  assign alu_y = y_r;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] s);
    case (s)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  // Outstanding ops in order: {sel, y} and the edge from which the result
  // must be visible at the FIFO head (accept edge + 3).
  logic [W+1:0] exp_q[$];
  int           due_q[$];
  logic [W-1:0] pop_log[$];
  int           pop_cyc[$];
  int           err_due = NEVER;
  logic         corrupt_req = 1'b0;
  bit           v_exp, r_exp, e_exp;
  int           k;

  // One compare process, sampling 2 ns before each rising edge.
  always @(negedge clk) begin
    #3;
    k = cyc;
    if (!rst_n) begin
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_y", bus.rsp_y, 0);
      chk("rst_err", err, 0);
      exp_q.delete();
      due_q.delete();
      err_due = NEVER;
      c_next  = 1'b0;
    end else begin
      v_exp = (exp_q.size() > 0) && (due_q[0] <= k);
      r_exp = (exp_q.size() < DEPTH);
      e_exp = CHECK_ON && (err_due <= k);
      chk("req_ready", bus.req_ready, r_exp);
      chk("rsp_valid", bus.rsp_valid, v_exp);
      chk("err", err, e_exp);
      if (v_exp) begin
        chk("rsp_y", bus.rsp_y, exp_q[0][W-1:0]);
        chk("rsp_sel", bus.rsp_sel, exp_q[0][W+1:W]);
      end
      c_next = 1'b0;
      if (bus.req_valid && r_exp) begin
        exp_q.push_back({bus.req_sel,
                         ref_op(bus.req_a, bus.req_b, bus.req_sel) ^ {{(W-1){1'b0}}, corrupt_req}});
        due_q.push_back(k + 4);
        if (corrupt_req && err_due == NEVER) err_due = k + 4;
        c_next = corrupt_req;
      end
      if (v_exp && bus.rsp_ready) begin
        pop_log.push_back(bus.rsp_y);
        pop_cyc.push_back(k);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #2;
  endtask

  task automatic slot();
    @(negedge clk); #3;
  endtask

  task automatic rand_req();
    bus.req_a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
    bus.req_b   = ($urandom_range(0, 7) == 0) ? 16'h0001 : W'($urandom);
    bus.req_sel = 2'($urandom_range(0, 3));
  endtask

  // Holds a request until accepted; returns 2 ns after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] s, input logic cor);
    bit got = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = s;
    corrupt_req   = cor;
    for (int t = 0; t < 50 && !got; t++) begin
      slot();
      got = bus.req_ready;
      sync();
    end
    bus.req_valid = 1'b0;
    corrupt_req   = 1'b0;
    chk("issue_accepted", got, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      sync();
      t++;
    end
    sync();
    chk("drain_done", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] t2_exp [4];
  int           acc;
  bit           got;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    sync();

    // 1: single add, latency and value
    issue(16'h1234, 16'h0F0F, 2'b00, 1'b0);
    @(posedge clk); @(posedge clk); slot();
    chk("t1_valid_early", bus.rsp_valid, 0);
    @(posedge clk); slot();
    chk("t1_valid", bus.rsp_valid, 1);
    chk("t1_y", bus.rsp_y, 16'h2143);
    chk("t1_sel", bus.rsp_sel, 0);
    chk("t1_err", err, 0);
    sync();
    drain();

    // 2: back-to-back, all four selects
    pop_log.delete(); pop_cyc.delete();
    for (int s = 0; s < 4; s++) issue(16'h00F0, 16'h0FF0, 2'(s), 1'b0);
    drain();
    t2_exp[0] = 16'h10E0; t2_exp[1] = 16'hF100; t2_exp[2] = 16'h00F0; t2_exp[3] = 16'h0FF0;
    chk("t2_count", pop_log.size(), 4);
    if (pop_log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t2_y", pop_log[i], t2_exp[i]);
        chk("t2_consecutive", pop_cyc[i], pop_cyc[0] + i);
      end

    // 3: wrap-around
    pop_log.delete();
    issue(16'hFFFF, 16'h0001, 2'b00, 1'b0);
    issue(16'h0000, 16'h0001, 2'b01, 1'b0);
    drain();
    chk("t3_count", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      chk("t3_add_wrap", pop_log[0], 16'h0000);
      chk("t3_sub_wrap", pop_log[1], 16'hFFFF);
    end

    // 4: backpressure and credit return
    bus.rsp_ready = 1'b0;
    pop_log.delete();
    acc = 0;
    bus.req_valid = 1'b1;
    rand_req();
    for (int i = 0; i < 8; i++) begin
      slot();
      got = bus.req_ready;
      if (got) acc++;
      sync();
      if (got) rand_req();
    end
    chk("t4_accepted", acc, 4);
    slot(); chk("t4_full_ready", bus.req_ready, 0);
    sync(); bus.rsp_ready = 1'b1;
    slot(); chk("t4_ready_same_cycle", bus.req_ready, 0);
    sync(); bus.rsp_ready = 1'b0;
    slot(); chk("t4_ready_next", bus.req_ready, 1);
    sync(); bus.req_valid = 1'b0;
    slot(); chk("t4_full_again", bus.req_ready, 0);
    sync(); bus.rsp_ready = 1'b1;
    drain();
    chk("t4_results", pop_log.size(), 5);

    // 5: reset with one buffered and two in flight
    bus.rsp_ready = 1'b0;
    issue(16'h1111, 16'h2222, 2'b00, 1'b0);
    sync();
    issue(16'h3333, 16'h0101, 2'b01, 1'b0);
    issue(16'h5555, 16'h0F0F, 2'b11, 1'b0);
    rst_n = 1'b0;
    slot();
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_sel", alu_sel, 0);
    sync(); sync();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    pop_log.delete();
    repeat (6) sync();
    chk("t5_no_stale", pop_log.size(), 0);
    issue(16'h0003, 16'h0005, 2'b10, 1'b0);
    drain();
    chk("t5_new_count", pop_log.size(), 1);
    if (pop_log.size() == 1) chk("t5_new_y", pop_log[0], 16'h0001);

    // 6: corrupted capture
    pop_log.delete();
    issue(16'h0001, 16'h0001, 2'b00, 1'b1);
    @(posedge clk); @(posedge clk); slot();
    chk("t6_err_before", err, 0);
    @(posedge clk); slot();
    chk("t6_err", err, CHECK_ON);
    sync();
    drain();
    chk("t6_count", pop_log.size(), 1);
    if (pop_log.size() == 1) chk("t6_corrupt_y", pop_log[0], 16'h0003);

    // random traffic; err must stay as set above
    for (int i = 0; i < 400; i++) begin
      slot();
      got = bus.req_valid && bus.req_ready;
      sync();
      if (got || !bus.req_valid) begin
        bus.req_valid = ($urandom_range(0, 3) != 0);
        rand_req();
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    drain();
    chk("final_err", err, CHECK_ON);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
